// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared FSM encoding and frame constants for uart_rx_wr    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int DEF_DIV   = 208;
  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_cnt : bit-period counter with mid-bit and end-of-bit flags |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_baud_cnt #(
  parameter int DIV = 208
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic mid_pulse,
  output logic end_pulse
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mid_pulse = (cnt_q == CNT_W'(DIV/2 - 1));
  assign end_pulse = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || end_pulse) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_wr : 8N1 UART receiver writing good bytes into a ring buffer |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_wr
  import uart_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int ADR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [ADR_W-1:0] rd_ptr,
  input  logic             ovf_clr,
  output logic [ADR_W-1:0] ram_wadr,
  output logic [7:0]       ram_wdata,
  output logic             ram_wen,
  output logic [ADR_W-1:0] wr_ptr,
  output logic             frame_err,
  output logic             ovf
);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rxs_q, rxs_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 wen_q, wen_d;
  logic [ADR_W-1:0]     wp_q, wp_d;
  logic                 ferr_q, ferr_d;
  logic                 ovf_q, ovf_d;

  logic                 mid_pulse, end_pulse, restart;
  logic [ADR_W-1:0]     wp_inc;
  logic                 full;

  // Counter reloads whenever the FSM changes state and is parked while idle.
  assign restart = (state_d != state_q) || (state_q == ST_IDLE);

  uart_baud_cnt #(.DIV(DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .mid_pulse (mid_pulse),
    .end_pulse (end_pulse)
  );

  assign wp_inc = wp_q + 1'b1;
  assign full   = (wp_inc == rd_ptr);

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    ferr_d    = 1'b0;
    ovf_d     = ovf_q & ~ovf_clr;
    // Pointer advances as the one-cycle strobe drops.
    wp_d      = wen_q ? wp_inc : wp_q;

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (mid_pulse) begin
          if (!rxs_q) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (end_pulse) begin
          sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (end_pulse) begin
          state_d = ST_IDLE;
          if (!rxs_q) begin
            ferr_d = 1'b1;
          end else if (full) begin
            ovf_d = 1'b1;
          end else begin
            wen_d   = 1'b1;
            wdata_d = sh_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      bit_q     <= '0;
      sh_q      <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      wp_q      <= '0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      wp_q      <= wp_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ram_wadr  = wp_q;
  assign ram_wdata = wdata_q;
  assign ram_wen   = wen_q;
  assign wr_ptr    = wp_q;
  assign frame_err = ferr_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_wr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_wr : self-checking bench for uart_rx_wr against a model   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx_wr;

  localparam int DIV   = 16;
  localparam int ADR_W = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic [ADR_W-1:0] rd_ptr;
  logic             ovf_clr;
  logic [ADR_W-1:0] ram_wadr;
  logic [7:0]       ram_wdata;
  logic             ram_wen;
  logic [ADR_W-1:0] wr_ptr;
  logic             frame_err;
  logic             ovf;

  always #5 clk = ~clk;

  uart_rx_wr #(.DIV(DIV), .ADR_W(ADR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_ptr    (rd_ptr),
    .ovf_clr   (ovf_clr),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .wr_ptr    (wr_ptr),
    .frame_err (frame_err),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [ADR_W-1:0] a;
    logic [7:0]       d;
  } wr_t;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   obs_ferr, exp_ferr, wen_long;
  logic wen_prev;
  int   m_wp;
  logic m_ovf;
  int   checks = 0;
  int   errors = 0;

  // Observer: log every write strobe and frame-error pulse.
  always @(negedge clk) begin
    if (rst) begin
      wen_prev = 1'b0;
    end else begin
      if (ram_wen) obs_q.push_back({ram_wadr, ram_wdata});
      if (ram_wen && wen_prev) wen_long++;
      wen_prev = ram_wen;
      if (frame_err) obs_ferr++;
    end
  end

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    obs_ferr = 0;
    exp_ferr = 0;
    wen_long = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_wp = 0; m_ovf = 1'b0;
    clear_logs();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Reference: a ring buffer that keeps one slot free.
  task automatic send_model(input logic [7:0] d, input logic stop);
    if (!stop) exp_ferr++;
    else if (((m_wp + 1) % DEPTH) == int'(rd_ptr)) m_ovf = 1'b1;
    else begin
      exp_q.push_back({3'(m_wp), d});
      m_wp = (m_wp + 1) % DEPTH;
    end
    send_frame(d, stop);
  endtask

  task automatic test_reset();
    rx = 1'b1; ovf_clr = 1'b0; rd_ptr = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ram_wen, frame_err, ovf} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: wen/ferr/ovf=%b expected 000", {ram_wen, frame_err, ovf}); end
    checks++; if (wr_ptr !== 3'd0 || ram_wadr !== 3'd0) begin errors++;
      $display("FAIL reset_ptr: wr_ptr=%0d wadr=%0d expected 0", wr_ptr, ram_wadr); end
    checks++; if (ram_wdata !== 8'h00) begin errors++;
      $display("FAIL reset_wdata: got %h expected 00", ram_wdata); end
    rst = 1'b0;
    m_wp = 0; m_ovf = 1'b0;
    clear_logs();
    idle(4);
  endtask

  task automatic test_basic();
    rd_ptr = '0;
    send_model(8'h55, 1'b1); idle(4);
    send_model(8'hA3, 1'b1); idle(4);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL basic_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL basic_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (wr_ptr !== 3'(m_wp)) begin errors++;
      $display("FAIL basic_wr_ptr: got %0d expected %0d", wr_ptr, m_wp); end
    checks++; if (obs_ferr != 0 || ovf !== 1'b0 || wen_long != 0) begin errors++;
      $display("FAIL basic_flags: ferr=%0d ovf=%b long=%0d expected 0 0 0", obs_ferr, ovf, wen_long); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h96;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx = d[4];
    repeat (DIV/2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({ram_wen, frame_err, ovf, wr_ptr, ram_wdata} !== 14'd0) begin errors++;
      $display("FAIL async_reset: wen=%b ferr=%b ovf=%b wr_ptr=%0d wdata=%h expected all 0",
               ram_wen, frame_err, ovf, wr_ptr, ram_wdata); end
    @(negedge clk); rx = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_wp = 0; m_ovf = 1'b0;
    clear_logs();
    idle(DIV);
    rd_ptr = '0;
    send_model(8'hC7, 1'b1); idle(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++;
      $display("FAIL post_reset_write: got %0d writes first=%h expected %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 11'h0, exp_q[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    rd_ptr = '0;
    for (int v = 1; v <= 8; v++) begin
      send_model(8'(v), 1'b1); idle(2);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL ovf_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL ovf_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== m_ovf || wr_ptr !== 3'(m_wp)) begin errors++;
      $display("FAIL ovf_state: ovf=%b wr_ptr=%0d expected %b %0d", ovf, wr_ptr, m_ovf, m_wp); end
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; @(negedge clk);
    m_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clr: got %b expected 0", ovf); end
  endtask

  task automatic test_frame_err();
    int wp0;
    clear_logs();
    rd_ptr = 3'(m_wp);
    wp0 = m_wp;
    send_model(8'h3C, 1'b0); idle(2*DIV);
    checks++; if (obs_ferr != 1 || obs_q.size() != 0 || wr_ptr !== 3'(wp0)) begin errors++;
      $display("FAIL ferr_bad: ferr=%0d writes=%0d wr_ptr=%0d expected 1 0 %0d",
               obs_ferr, obs_q.size(), wr_ptr, wp0); end
    send_model(8'h3C, 1'b1); idle(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++;
      $display("FAIL ferr_recover: got %0d writes first=%h expected %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 11'h0, exp_q[0]); end
  endtask

  task automatic test_glitch();
    clear_logs();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3*DIV);
    checks++; if (obs_q.size() != 0 || obs_ferr != 0) begin errors++;
      $display("FAIL glitch: writes=%0d ferr=%0d expected 0 0", obs_q.size(), obs_ferr); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rd_ptr = 3'((m_wp + DEPTH - 1) % DEPTH);
      send_model(8'($urandom_range(0, 255)), 1'b1); idle(2);
    end
    checks++; if (obs_q.size() != 10) begin errors++;
      $display("FAIL wrap_count: got %0d writes expected 10", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i] || obs_q[i].a !== 3'(i % DEPTH)) begin errors++;
        $display("FAIL wrap_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== 1'b0 || wr_ptr !== 3'd2) begin errors++;
      $display("FAIL wrap_state: ovf=%b wr_ptr=%0d expected 0 2", ovf, wr_ptr); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      rd_ptr = 3'($urandom_range(0, DEPTH - 1));
      send_model(8'($urandom_range(0, 255)), 1'b1);
    end
    idle(DIV);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL b2b_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL b2b_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf !== m_ovf || wr_ptr !== 3'(m_wp) || wen_long != 0) begin errors++;
      $display("FAIL b2b_state: ovf=%b wr_ptr=%0d long=%0d expected %b %0d 0",
               ovf, wr_ptr, wen_long, m_ovf, m_wp); end
  endtask

  task automatic test_break();
    int wp0;
    clear_logs();
    rd_ptr = 3'(m_wp);
    wp0 = m_wp;
    // 29 bit times low: three complete failed frames, released before the fourth start sample.
    rx = 1'b0;
    repeat (29*DIV) @(negedge clk);
    idle(4*DIV);
    checks++; if (obs_ferr != 3 || obs_q.size() != 0 || wr_ptr !== 3'(wp0)) begin errors++;
      $display("FAIL break: ferr=%0d writes=%0d wr_ptr=%0d expected 3 0 %0d",
               obs_ferr, obs_q.size(), wr_ptr, wp0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_midframe();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_wrap();
    test_back_to_back();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
